// File: rtl/scandouble_mode_ctrl.sv
// scandouble_mode_ctrl
//
// Sequences 15k/31k scandoubler mode changes so the display never sees a
// mid-frame switch. A mode request is taken at a frame boundary, the video is
// blanked for BLANK_FRAMES frames in the old mode, the scandouble select is
// flipped, and blanking is held for SETTLE_FRAMES frames while the monitor
// re-locks. A watchdog substitutes a synthetic frame edge when vsync is absent.
//
// Ports:
//   clk_peripheral_n  in   system clock, rising-edge active
//   reset_n           in   asynchronous active-low reset
//   scandouble_req    in   requested mode (1 = 31k), asynchronous level
//   vsync             in   native frame sync, active-low, asynchronous
//   bypass            in   (SCANDOUBLE_MODE_CTRL_BYPASS_EN only) pass req straight through
//   scandouble        out  mode select to the scandoubler
//   blank             out  1 = force RGB to zero downstream
//   busy              out  1 = sequence in progress
//   frame_tick        out  one-cycle pulse per detected vsync falling edge
//
// Optional feature macro: SCANDOUBLE_MODE_CTRL_BYPASS_EN adds the bypass input.

module scandouble_mode_ctrl #(
    parameter int unsigned BLANK_FRAMES     = 2,
    parameter int unsigned SETTLE_FRAMES    = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 1048576,
    parameter logic        SCANDOUBLE_RESET = 1'b1
) (
    input  logic clk_peripheral_n,
    input  logic reset_n,
    input  logic scandouble_req,
    input  logic vsync,
`ifdef SCANDOUBLE_MODE_CTRL_BYPASS_EN
    input  logic bypass,
`endif
    output logic scandouble,
    output logic blank,
    output logic busy,
    output logic frame_tick
);

    localparam int unsigned    WdW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [WdW-1:0] WdMax     = WdW'(TIMEOUT_CYCLES - 1);
    localparam logic [WdW-1:0] WdOne     = WdW'(1);
    localparam logic [3:0]     BlankCnt  = 4'(BLANK_FRAMES);
    localparam logic [3:0]     SettleCnt = 4'(SETTLE_FRAMES);

    typedef enum logic [2:0] {
        StIdle,
        StWaitVs,
        StBlank,
        StSwitch,
        StSettle
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           target_q, target_d;
    logic           sd_q, sd_d;
    logic           tick_q;

    // Synchronisers; vsync idles high so its flops reset high to avoid a
    // spurious edge straight out of reset.
    logic vs_meta_q, vs_sync_q, vs_prev_q;
    logic req_meta_q, req_sync_q;
    logic byp_active;

    always_ff @(posedge clk_peripheral_n or negedge reset_n) begin
        if (!reset_n) begin
            vs_meta_q  <= 1'b1;
            vs_sync_q  <= 1'b1;
            vs_prev_q  <= 1'b1;
            req_meta_q <= SCANDOUBLE_RESET;
            req_sync_q <= SCANDOUBLE_RESET;
        end else begin
            vs_meta_q  <= vsync;
            vs_sync_q  <= vs_meta_q;
            vs_prev_q  <= vs_sync_q;
            req_meta_q <= scandouble_req;
            req_sync_q <= req_meta_q;
        end
    end

`ifdef SCANDOUBLE_MODE_CTRL_BYPASS_EN
    logic byp_meta_q, byp_sync_q;

    always_ff @(posedge clk_peripheral_n or negedge reset_n) begin
        if (!reset_n) begin
            byp_meta_q <= 1'b0;
            byp_sync_q <= 1'b0;
        end else begin
            byp_meta_q <= bypass;
            byp_sync_q <= byp_meta_q;
        end
    end

    assign byp_active = byp_sync_q;
`else
    assign byp_active = 1'b0;
`endif

    logic frame_edge;
    logic counting;
    logic timeout;
    logic frame_ev;

    assign frame_edge = vs_prev_q & ~vs_sync_q;
    assign counting   = (state_q == StWaitVs) || (state_q == StBlank) || (state_q == StSettle);
    assign timeout    = counting && (wd_q == WdMax);
    // A watchdog expiry stands in for a missing frame edge.
    assign frame_ev   = frame_edge | timeout;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        sd_d     = sd_q;
        wd_d     = wd_q;

        case (state_q)
            StIdle: begin
                if (req_sync_q != sd_q) begin
                    target_d = req_sync_q;
                    state_d  = StWaitVs;
                end
            end
            StWaitVs: begin
                if (frame_ev) begin
                    cnt_d   = 4'd0;
                    state_d = StBlank;
                end
            end
            StBlank: begin
                if (frame_ev) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == BlankCnt) begin
                        state_d = StSwitch;
                    end
                end
            end
            StSwitch: begin
                // Edges seen here are ignored so nothing is counted twice.
                sd_d    = target_q;
                cnt_d   = 4'd0;
                state_d = StSettle;
            end
            StSettle: begin
                if (frame_ev) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == SettleCnt) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Bypass parks the sequencer and tracks the request directly.
        if (byp_active) begin
            state_d = StIdle;
            sd_d    = req_sync_q;
        end

        if (!counting || frame_ev || (state_d != state_q)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WdOne;
        end
    end

    always_ff @(posedge clk_peripheral_n or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StSettle;
            cnt_q    <= 4'd0;
            wd_q     <= '0;
            target_q <= SCANDOUBLE_RESET;
            sd_q     <= SCANDOUBLE_RESET;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            target_q <= target_d;
            sd_q     <= sd_d;
            tick_q   <= frame_edge;
        end
    end

    assign busy       = (state_q != StIdle) & ~byp_active;
    assign blank      = ((state_q == StBlank) || (state_q == StSwitch) || (state_q == StSettle))
                        & ~byp_active;
    assign scandouble = byp_active ? req_sync_q : sd_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_scandouble_mode_ctrl.sv
// Testbench for scandouble_mode_ctrl: table of per-frame steps, with expected
// {scandouble, blank, busy} pushed to a scoreboard when vsync is pulsed and
// popped when the DUT raises frame_tick. A second instance with a short
// watchdog covers the vsync-absent case.

module tb_scandouble_mode_ctrl;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic req      = 1'b1;
    logic vsync    = 1'b1;
    logic sd, blank, busy, ft;

    logic rst_to_n = 1'b0;
    logic req_to   = 1'b1;
    logic vsync_to = 1'b1;
    logic sd_to, blank_to, busy_to, ft_to;

    always #5 clk = ~clk;

`ifdef SCANDOUBLE_MODE_CTRL_BYPASS_EN
    logic bypass = 1'b0;
`endif

    scandouble_mode_ctrl dut (
        .clk_peripheral_n (clk),
        .reset_n          (reset_n),
        .scandouble_req   (req),
        .vsync            (vsync),
`ifdef SCANDOUBLE_MODE_CTRL_BYPASS_EN
        .bypass           (bypass),
`endif
        .scandouble       (sd),
        .blank            (blank),
        .busy             (busy),
        .frame_tick       (ft)
    );

    scandouble_mode_ctrl #(
        .TIMEOUT_CYCLES (64)
    ) dut_to (
        .clk_peripheral_n (clk),
        .reset_n          (rst_to_n),
        .scandouble_req   (req_to),
        .vsync            (vsync_to),
`ifdef SCANDOUBLE_MODE_CTRL_BYPASS_EN
        .bypass           (1'b0),
`endif
        .scandouble       (sd_to),
        .blank            (blank_to),
        .busy             (busy_to),
        .frame_tick       (ft_to)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    // One table step: optional reset, set req, check state, then optionally
    // pulse vsync once and expect {sd,blank,busy} after that frame edge.
    typedef struct packed {
        logic       rst;
        logic       frame;
        logic       req;
        logic [2:0] pre;
        logic [2:0] post;
    } step_t;

    step_t      tbl[$];
    logic [2:0] exp_q[$];
    logic [2:0] e_pop;
    int         frame_no = 0;
    logic       sd_prev  = 1'bx;
    bit         mon_en   = 1'b1;

    task automatic add(input logic r, input logic f, input logic q,
                       input logic [2:0] pre, input logic [2:0] post);
        step_t s;
        s = '{rst: r, frame: f, req: q, pre: pre, post: post};
        tbl.push_back(s);
    endtask

    // Scoreboard consumer and blank-while-switching monitor.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && ft === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected frame_tick: got 1, required 0");
            end else begin
                e_pop = exp_q.pop_front();
                check($sformatf("frame %0d sd/blank/busy", frame_no), {sd, blank, busy}, e_pop);
            end
            frame_no++;
        end
        if (mon_en && reset_n === 1'b1 && sd_prev !== 1'bx && sd !== sd_prev) begin
            check("scandouble changed while unblanked", {2'b00, blank}, 3'b001);
        end
        sd_prev <= sd;
    end

    initial begin
        #2_000_000;
        $display("FAIL global time limit: got timeout, required finish");
        $fatal(1, "time limit");
    end

    initial begin
        bit ft_seen;

        // Reset then SETTLE of 4 frames.
        add(1, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b100);
        // req 1->0, back to 1 during BLANK: completes to 0, then second sequence to 1.
        add(0, 1, 0, 3'b101, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b011, 3'b011);
        add(0, 1, 1, 3'b011, 3'b011);
        add(0, 1, 1, 3'b011, 3'b011);
        add(0, 1, 1, 3'b011, 3'b000);
        add(0, 1, 1, 3'b001, 3'b011);
        add(0, 1, 1, 3'b011, 3'b011);
        add(0, 1, 1, 3'b011, 3'b011);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b100);
        // req 1->0; during SETTLE req toggles and returns, no new sequence.
        add(0, 1, 0, 3'b101, 3'b111);
        add(0, 1, 0, 3'b111, 3'b111);
        add(0, 1, 0, 3'b111, 3'b111);
        add(0, 1, 1, 3'b011, 3'b011);
        add(0, 1, 0, 3'b011, 3'b011);
        add(0, 1, 0, 3'b011, 3'b011);
        add(0, 1, 0, 3'b011, 3'b000);
        add(0, 0, 0, 3'b000, 3'b000);
        // Back to 1, then start 1->0 and reset while settling in mode 0.
        add(0, 1, 1, 3'b001, 3'b011);
        add(0, 1, 1, 3'b011, 3'b011);
        add(0, 1, 1, 3'b011, 3'b011);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b100);
        add(0, 1, 0, 3'b101, 3'b111);
        add(0, 1, 0, 3'b111, 3'b111);
        add(0, 1, 0, 3'b111, 3'b111);
        add(0, 1, 0, 3'b011, 3'b011);
        add(1, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b111);
        add(0, 1, 1, 3'b111, 3'b100);

        repeat (3) @(negedge clk);
        rst_to_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            req = tbl[i].req;
            if (tbl[i].rst) begin
                reset_n = 1'b0;
                #1;
                check($sformatf("step %0d reset outputs", i), {sd, blank, busy}, tbl[i].pre);
                check($sformatf("step %0d reset frame_tick", i), {2'b00, ft}, 3'b000);
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                repeat (50) @(negedge clk);
            end else begin
                repeat (50) @(negedge clk);
                check($sformatf("step %0d pre-frame state", i), {sd, blank, busy}, tbl[i].pre);
            end
            if (tbl[i].frame) begin
                exp_q.push_back(tbl[i].post);
                vsync = 1'b0;
                repeat (4) @(negedge clk);
                vsync = 1'b1;
                repeat (46) @(negedge clk);
            end
        end
        check("scoreboard drained", {2'b00, exp_q.size() == 0}, 3'b001);

        // No vsync: watchdog of 64 clocks drives every phase.
        check("timeout dut idle", {sd_to, blank_to, busy_to}, 3'b100);
        @(negedge clk);
        req_to  = 1'b0;
        ft_seen = 1'b0;
        for (int c = 1; c <= 460; c++) begin
            @(negedge clk);
            if (ft_to === 1'b1) ft_seen = 1'b1;
            case (c)
                66:  check("timeout still waiting", {sd_to, blank_to, busy_to}, 3'b101);
                67:  check("timeout enters blank", {sd_to, blank_to, busy_to}, 3'b111);
                195: check("timeout before switch", {sd_to, blank_to, busy_to}, 3'b111);
                196: check("timeout switched", {sd_to, blank_to, busy_to}, 3'b011);
                451: check("timeout still settling", {sd_to, blank_to, busy_to}, 3'b011);
                452: check("timeout back to idle", {sd_to, blank_to, busy_to}, 3'b000);
                default: ;
            endcase
        end
        check("timeout no frame_tick", {2'b00, ft_seen}, 3'b000);

`ifdef SCANDOUBLE_MODE_CTRL_BYPASS_EN
        mon_en = 1'b0;
        bypass = 1'b1;
        repeat (4) @(negedge clk);
        check("bypass idle", {sd, blank, busy}, 3'b100);
        req = 1'b0;
        @(negedge clk);
        check("bypass 1 cycle", {sd, blank, busy}, 3'b100);
        @(negedge clk);
        check("bypass 2 cycles", {sd, blank, busy}, 3'b000);
        req = 1'b1;
        @(negedge clk);
        check("bypass back 1 cycle", {sd, blank, busy}, 3'b000);
        @(negedge clk);
        check("bypass back 2 cycles", {sd, blank, busy}, 3'b100);
        bypass = 1'b0;
        repeat (10) @(negedge clk);
        check("bypass released", {sd, blank, busy}, 3'b100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
